alu_bist: RTL and testbench

Built-in self-test controller for the ALU: it drives the ALU's operand and control inputs and checks its `ALU_result`/`zero_flag` outputs against an internal golden model. It sits beside the ALU in the single-cycle CPU datapath and takes over the ALU inputs only while `busy` is high; the datapath mux select is `busy`. It replaces hand-written stimulus with a repeatable on-chip sweep and reports a pass/fail summary.

---
 rtl/alu_bist.sv | 209 ++++++++++++++++++++
 tb/tb_alu_bist.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test controller for the single-cycle CPU ALU.
// Sweeps NUM_VECTORS operand pairs through all 8 ALU ops, checks the ALU's
// result and zero flag against an internal golden model and reports a
// pass/fail summary. The datapath hands the ALU inputs over while busy=1.
// Optional build macro: ALU_BIST_STOP_ON_FAIL_EN (end the run on the first
// failing check, holding the failing stimulus on a/b/ALU_control).
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | a/b/ALU_control just updated for the current check
// SETTLE | waiting SETTLE_CYCLES for the combinational ALU to settle
// CHECK  | compare ALU outputs; result recorded on the exit edge
// DONE   | run finished, summary outputs valid until next start
module alu_bist #(
  parameter int          NUM_VECTORS   = 16,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ALU_result,
  input  logic        zero_flag,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  ALU_control,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_count,
  output logic [15:0] first_fail_index
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] NO_FAIL     = 16'hFFFF;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  logic [2:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_ctrl;
  logic [31:0] r_lfsr;
  logic [15:0] r_vec;
  logic [2:0]  r_op;
  logic [15:0] r_settle_cnt;
  logic [15:0] r_fail_count;
  logic [15:0] r_first_fail;

  logic [31:0] w_expected;
  logic        w_fail;
  logic        w_accept;
  logic        w_check_fail;
  logic        w_last_check;
  logic [31:0] w_lfsr_2;
  logic [31:0] w_lfsr_3;
  logic [15:0] w_check_index;

  function automatic logic [3:0] op_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return OP_AND;
      3'd1:    return OP_OR;
      3'd2:    return OP_ADD;
      3'd3:    return OP_SUB;
      3'd4:    return OP_XOR;
      3'd5:    return OP_SLL;
      3'd6:    return OP_SRL;
      default: return OP_SLT;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
  endfunction

  // next vector's operands: the LFSR moves two steps per vector, b is one step ahead of a
  assign w_lfsr_2 = lfsr_step(lfsr_step(r_lfsr));
  assign w_lfsr_3 = lfsr_step(w_lfsr_2);

  assign w_accept      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_check  = (r_vec == LAST_VEC) && (r_op == 3'd7);
  assign w_check_index = {r_vec[12:0], r_op};
  assign w_check_fail  = (r_state == ST_CHECK) && w_fail;

  // golden ALU model evaluated on the registered stimulus
  always_comb begin
    w_expected = 32'd0;
    case (r_ctrl)
      OP_AND:  w_expected = r_a & r_b;
      OP_OR:   w_expected = r_a | r_b;
      OP_ADD:  w_expected = r_a + r_b;
      OP_SUB:  w_expected = r_a - r_b;
      OP_XOR:  w_expected = r_a ^ r_b;
      OP_SLL:  w_expected = r_a << r_b[4:0];
      OP_SRL:  w_expected = r_a >> r_b[4:0];
      OP_SLT:  w_expected = {31'd0, ($signed(r_a) < $signed(r_b))};
      default: w_expected = 32'd0;
    endcase
  end

  assign w_fail = (ALU_result != w_expected) || (zero_flag != (w_expected == 32'd0));

  // sequencing FSM, stimulus registers and LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_ctrl       <= OP_AND;
      r_lfsr       <= SEED;
      r_vec        <= 16'd0;
      r_op         <= 3'd0;
      r_settle_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_ctrl  <= OP_AND;
            r_lfsr  <= SEED;
            r_vec   <= 16'd0;
            r_op    <= 3'd0;
          end
        end
        ST_LOAD: begin
          r_state      <= ST_SETTLE;
          r_settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 16'd0) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt - 16'd1;
          end
        end
        ST_CHECK: begin
          if (w_last_check || (STOP_ON_FAIL && w_fail)) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_LOAD;
            if (r_op == 3'd7) begin
              r_vec  <= r_vec + 16'd1;
              r_op   <= 3'd0;
              r_lfsr <= w_lfsr_2;
              r_a    <= w_lfsr_2;
              r_b    <= w_lfsr_3;
              r_ctrl <= op_code(3'd0);
            end else begin
              r_op   <= r_op + 3'd1;
              r_ctrl <= op_code(r_op + 3'd1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // failure bookkeeping: cleared on an accepted start, updated on the CHECK exit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_count <= 16'd0;
      r_first_fail <= NO_FAIL;
    end else if (w_accept) begin
      r_fail_count <= 16'd0;
      r_first_fail <= NO_FAIL;
    end else if (w_check_fail) begin
      if (r_fail_count != 16'hFFFF) begin
        r_fail_count <= r_fail_count + 16'd1;
      end
      if (r_first_fail == NO_FAIL) begin
        r_first_fail <= w_check_index;
      end
    end
  end

  assign a                = r_a;
  assign b                = r_b;
  assign ALU_control      = r_ctrl;
  assign busy             = (r_state == ST_LOAD) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done             = (r_state == ST_DONE);
  assign pass             = done && (r_fail_count == 16'd0);
  assign fail_count       = r_fail_count;
  assign first_fail_index = r_first_fail;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural ALU with injectable per-op faults sits on
// the DUT outputs; stimulus sequence, run length and summary outputs are
// predicted from the operation rules.
module tb_alu_bist;

  localparam int          NV   = 4;
  localparam int          SC   = 1;
  localparam int          P    = 2 + SC;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] dut_a;
  logic [31:0] dut_b;
  logic [3:0]  dut_ctrl;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] fail_count;
  logic [15:0] first_fail_index;

  logic [7:0]  res_mask;
  logic [7:0]  zf_mask;
  logic [32:0] alu_out;

  logic [31:0] exp_a [NV];
  logic [31:0] exp_b [NV];

  int n_checks;
  int n_fail;

  alu_bist #(
    .NUM_VECTORS   (NV),
    .SETTLE_CYCLES (SC),
    .SEED          (SEED)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .ALU_result       (alu_result),
    .zero_flag        (zero_flag),
    .a                (dut_a),
    .b                (dut_b),
    .ALU_control      (dut_ctrl),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_count       (fail_count),
    .first_fail_index (first_fail_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] op_code(input int idx);
    case (idx)
      0:       return 4'b0000;
      1:       return 4'b0001;
      2:       return 4'b0011;
      3:       return 4'b0100;
      4:       return 4'b0101;
      5:       return 4'b0110;
      6:       return 4'b0111;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input int idx, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (idx)
      0:       return x & y;
      1:       return x | y;
      2:       return x + y;
      3:       return x - y;
      4:       return x ^ y;
      5:       return x << sh;
      6:       return x >> sh;
      default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // behavioural ALU; a faulted op returns result+1, a zero-flag fault inverts the flag
  function automatic logic [32:0] fake_alu(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] c, input logic [7:0] rm,
                                           input logic [7:0] zm);
    logic [31:0] r;
    logic        z;
    r = 32'd0;
    z = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c == op_code(i)) begin
        r = ref_op(i, x, y);
        if (rm[i]) r = r + 32'd1;
        z = (r == 32'd0) ^ zm[i];
      end
    end
    return {z, r};
  endfunction

  always_comb begin
    alu_out    = fake_alu(dut_a, dut_b, dut_ctrl, res_mask, zf_mask);
    alu_result = alu_out[31:0];
    zero_flag  = alu_out[32];
  end

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_a"}, dut_a, 32'd0);
    chk({tag, "_b"}, dut_b, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, dut_ctrl}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_fcnt"}, {16'd0, fail_count}, 32'd0);
    chk({tag, "_ffi"}, {16'd0, first_fail_index}, 32'h0000_FFFF);
  endtask

  // one complete run from IDLE or DONE with a spurious start pulse while busy
  task automatic run_check(input logic [7:0] rm, input logic [7:0] zm, input string tag);
    logic [7:0] fm;
    int first, n_chk, exp_fails, run_len, spur, k, last;
    res_mask = rm;
    zf_mask  = zm;
    fm       = rm | zm;
    first    = -1;
    for (int i = 7; i >= 0; i--) if (fm[i]) first = i;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    n_chk     = (first < 0) ? NV * 8 : first + 1;
    exp_fails = (first < 0) ? 0 : 1;
`else
    n_chk     = NV * 8;
    exp_fails = 0;
    for (int i = 0; i < 8; i++) if (fm[i]) exp_fails += NV;
`endif
    run_len = n_chk * P;
    spur    = int'($urandom_range(1, run_len - 2));
    last    = n_chk - 1;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= run_len; t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
      if (t == spur) start = 1'b1;
      if (t == spur + 1) start = 1'b0;
      if ((t % P) == 1 && (t / P) < n_chk) begin
        k = t / P;
        chk({tag, "_stim_a"}, dut_a, exp_a[k / 8]);
        chk({tag, "_stim_b"}, dut_b, exp_b[k / 8]);
        chk({tag, "_stim_ctrl"}, {28'd0, dut_ctrl}, {28'd0, op_code(k % 8)});
        chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      end
      if (t == run_len - 1) begin
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      end
      if (t == run_len) begin
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, (exp_fails == 0) ? 32'd1 : 32'd0);
        chk({tag, "_fcnt"}, {16'd0, fail_count}, 32'(exp_fails));
        chk({tag, "_ffi"}, {16'd0, first_fail_index},
            (first < 0) ? 32'h0000_FFFF : 32'(first));
        chk({tag, "_hold_a"}, dut_a, exp_a[last / 8]);
        chk({tag, "_hold_b"}, dut_b, exp_b[last / 8]);
        chk({tag, "_hold_ctrl"}, {28'd0, dut_ctrl}, {28'd0, op_code(last % 8)});
      end
    end
    // done stays up with no new start
    repeat (2) @(negedge clk);
    chk({tag, "_done_held"}, {31'd0, done}, 32'd1);
  endtask

  // reset asserted asynchronously in the middle of a failing run
  task automatic reset_mid_run();
    res_mask = 8'h01;
    zf_mask  = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
    end
    chk("pre_rst_fcnt", {16'd0, fail_count}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_ffi", {16'd0, first_fail_index}, 32'h0000_FFFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    res_mask = 8'h00;
    zf_mask  = 8'h00;
    start    = 1'b0;
    rst_n    = 1'b0;

    for (int v = 0; v < NV; v++) begin
      exp_a[v] = (v == 0) ? 32'd0 : lfsr_adv(SEED, 2 * v);
      exp_b[v] = (v == 0) ? 32'd0 : lfsr_adv(SEED, 2 * v + 1);
    end

    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_check(8'h00, 8'h00, "golden");
    run_check(8'h00, 8'h00, "golden_rerun");
    run_check(8'h04, 8'h00, "add_fault");
    for (int r = 0; r < 3; r++) begin
      run_check(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                $sformatf("rand%0d", r));
    end
    reset_mid_run();
    run_check(8'h80, 8'h00, "slt_fault");
    run_check(8'h00, 8'h00, "golden_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
